// File: rtl/led_frame_ctrl.sv
// Serialises C_N-bit frames MSB-first into an LED driver chain, pulses LE, and PWM-blanks through LED_OE.
// Define LED_READBACK_EN to build the LED_SDO readback compare; without it Readback_Err is tied low.
module led_frame_ctrl #(
  parameter int C_N   = 16,
  parameter int C_DIV = 2
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic [C_N-1:0] Load_Data,
  input  logic           Load_Valid,
  output logic           Load_Ready,
  input  logic [3:0]     Bright,
  output logic           LED_Clk,
  output logic           LED_SDI,
  output logic           LED_LE,
  output logic           LED_OE,
  input  logic           LED_SDO,
  output logic           Frame_Done,
  output logic           Readback_Err
);

  localparam int DIV_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam int BIT_W = $clog2(C_N);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(C_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(C_N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [C_N-1:0]   shift_reg, shift_reg_nxt;
  logic             div_last;
  logic             done_nxt;
  logic             load_fire;

  assign div_last   = (div_cnt == DIV_LAST);
  assign Load_Ready = (state == IDLE);
  assign load_fire  = Load_Valid && Load_Ready;

  always_comb begin
    state_nxt     = state;
    div_cnt_nxt   = div_cnt;
    bit_cnt_nxt   = bit_cnt;
    shift_reg_nxt = shift_reg;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (load_fire) begin
          state_nxt     = SHIFT_LO;
          div_cnt_nxt   = '0;
          bit_cnt_nxt   = '0;
          shift_reg_nxt = Load_Data;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          state_nxt   = SHIFT_HI;
          div_cnt_nxt = '0;
        end else begin
          div_cnt_nxt = div_cnt + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_last) begin
          div_cnt_nxt   = '0;
          shift_reg_nxt = {shift_reg[C_N-2:0], 1'b0};
          if (bit_cnt == BIT_LAST) begin
            state_nxt = LATCH;
          end else begin
            state_nxt   = SHIFT_LO;
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end else begin
          div_cnt_nxt = div_cnt + 1'b1;
        end
      end
      LATCH: begin
        if (div_last) begin
          state_nxt   = IDLE;
          div_cnt_nxt = '0;
          done_nxt    = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pin outputs are decoded from the next state and registered so they never glitch off-chip.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      LED_Clk    <= 1'b0;
      LED_SDI    <= 1'b0;
      LED_LE     <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift_reg  <= shift_reg_nxt;
      LED_Clk    <= (state_nxt == SHIFT_HI);
      LED_SDI    <= ((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI)) && shift_reg_nxt[C_N-1];
      LED_LE     <= (state_nxt == LATCH);
      Frame_Done <= done_nxt;
    end
  end

  logic [3:0] pwm_cnt, pwm_nxt;
  logic [3:0] bright_q, bright_nxt;

  // Brightness only changes at the period boundary so a duty update never produces a runt pulse.
  assign pwm_nxt    = pwm_cnt + 4'd1;
  assign bright_nxt = (pwm_cnt == 4'd15) ? Bright : bright_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pwm_cnt  <= '0;
      bright_q <= '0;
      LED_OE   <= 1'b1;
    end else begin
      pwm_cnt  <= pwm_nxt;
      bright_q <= bright_nxt;
      LED_OE   <= (pwm_nxt >= bright_nxt);
    end
  end

`ifdef LED_READBACK_EN
  logic [C_N-1:0] rb_shift, cur_word, prev_word;
  logic           have_prev, rb_err;

  // SDO is sampled just before each rising LED_Clk, so it returns the word the chain held before this frame.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rb_shift  <= '0;
      cur_word  <= '0;
      prev_word <= '0;
      have_prev <= 1'b0;
      rb_err    <= 1'b0;
    end else begin
      if (load_fire) cur_word <= Load_Data;
      if ((state == SHIFT_LO) && div_last) rb_shift <= {rb_shift[C_N-2:0], LED_SDO};
      if (done_nxt) begin
        rb_err    <= have_prev && (rb_shift != prev_word);
        prev_word <= cur_word;
        have_prev <= 1'b1;
      end
    end
  end

  assign Readback_Err = rb_err;
`else
  logic unused_sdo;
  assign unused_sdo   = LED_SDO;
  assign Readback_Err = 1'b0;
`endif

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Bench for led_frame_ctrl: timeline-based reference model checked every cycle, directed literal
// checks of the reference frame, PWM and reset cases, then randomized traffic with a driver-chain model.
`timescale 1ns/1ps
module tb_led_frame_ctrl;
  localparam int N         = 16;
  localparam int DIV       = 2;
  localparam int SHIFT_LEN = 2 * DIV * N;
  localparam int DONE_K    = SHIFT_LEN + DIV;
`ifdef LED_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [N-1:0] Load_Data = '0;
  logic         Load_Valid = 1'b0;
  logic         Load_Ready;
  logic [3:0]   Bright = 4'd0;
  logic         LED_Clk, LED_SDI, LED_LE, LED_OE, LED_SDO, Frame_Done, Readback_Err;

  always #5 Clk = ~Clk;

  led_frame_ctrl #(.C_N(N), .C_DIV(DIV)) dut (
    .Clk(Clk), .Rst(Rst), .Load_Data(Load_Data), .Load_Valid(Load_Valid), .Load_Ready(Load_Ready),
    .Bright(Bright), .LED_Clk(LED_Clk), .LED_SDI(LED_SDI), .LED_LE(LED_LE), .LED_OE(LED_OE),
    .LED_SDO(LED_SDO), .Frame_Done(Frame_Done), .Readback_Err(Readback_Err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Driver chain: shift on LED_Clk, parallel outputs follow LE, SDO optionally forced low.
  logic [N-1:0] drv = '0;
  logic [N-1:0] po = '0;
  logic         sdo_force = 1'b0;
  logic         force_req = 1'b0;
  always @(posedge LED_Clk) drv <= {drv[N-2:0], LED_SDI};
  always @(posedge Clk) if (LED_LE) po <= drv;
  assign LED_SDO = sdo_force ? 1'b0 : drv[N-1];

  // Reference: a frame is just a start cycle and a word; everything else is arithmetic on the offset.
  bit           m_active = 0;
  int           m_T = 0;
  logic [N-1:0] m_word = '0;
  int           m_pwm = 0;
  int           m_bq = 0;
  bit           m_have_prev = 0;
  logic [N-1:0] m_prev = '0;
  logic [N-1:0] m_rb_exp = '0;
  bit           m_err = 0;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_active = 0; m_pwm = 0; m_bq = 0;
      m_have_prev = 0; m_err = 0; sdo_force = 1'b0;
    end else begin
      if (!(m_active && (cyc - m_T - 1) < DONE_K) && Load_Valid) begin
        m_active = 1; m_T = cyc; m_word = Load_Data;
        m_rb_exp = force_req ? '0 : drv;
        sdo_force = force_req;
      end
      if (m_pwm == 15) m_bq = int'(Bright);
      m_pwm = (m_pwm + 1) % 16;
      cyc++;
      if (m_active && (cyc - m_T - 1) == DONE_K) begin
        if (RB) begin
          m_err = m_have_prev && (m_rb_exp != m_prev);
          m_prev = m_word;
          m_have_prev = 1;
        end
        sdo_force = 1'b0;
      end
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    int k;
    bit shifting, latch, done, hi;
    k        = cyc - m_T - 1;
    shifting = m_active && k >= 0 && k < SHIFT_LEN;
    latch    = m_active && k >= SHIFT_LEN && k < DONE_K;
    done     = m_active && k == DONE_K;
    hi       = shifting && ((k % (2 * DIV)) >= DIV);
    check1("load_ready", Load_Ready, !(shifting || latch));
    check1("led_clk", LED_Clk, hi);
    check1("led_le", LED_LE, latch);
    check1("frame_done", Frame_Done, done);
    check1("led_oe", LED_OE, m_pwm >= m_bq);
    check1("readback_err", Readback_Err, m_err);
    if (shifting) check1("led_sdi", LED_SDI, m_word[N-1-k/(2*DIV)]);
  end

  // Event recorder for the directed literal checks.
  logic [N-1:0] sdi_cap = '0;
  int sdi_n = 0, le_first = -1, le_last = -1, le_pulses = 0, done_cyc = -1, done_cnt = 0;
  logic prev_lc = 1'b0, prev_le = 1'b0;
  always @(negedge Clk) begin
    if (LED_Clk && !prev_lc) begin sdi_cap = {sdi_cap[N-2:0], LED_SDI}; sdi_n++; end
    if (LED_LE && !prev_le) begin le_pulses++; le_first = cyc; end
    if (LED_LE) le_last = cyc;
    if (Frame_Done) begin done_cyc = cyc; done_cnt++; end
    prev_lc = LED_Clk;
    prev_le = LED_LE;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    Rst = 1'b1;
    repeat (n) tick();
    Rst = 1'b0;
  endtask

  task automatic clear_rec();
    sdi_n = 0; le_pulses = 0; le_first = -1; le_last = -1; done_cyc = -1;
  endtask

  task automatic send_frame(input logic [N-1:0] w, output int t);
    int waited = 0;
    while (!Load_Ready && waited < 300) begin tick(); waited++; end
    check1("send_ready", Load_Ready, 1'b1);
    Load_Data = w; Load_Valid = 1'b1; t = cyc;
    tick();
    Load_Valid = 1'b0;
  endtask

  task automatic count_on(output int on_cnt);
    on_cnt = 0;
    repeat (16) begin tick(); if (LED_OE === 1'b0) on_cnt++; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, acc, w, on_cnt, le_snap, done_snap;
    do_reset(3);
    check1("reset_ready", Load_Ready, 1'b1);
    check1("reset_oe", LED_OE, 1'b1);

    // Reference frame 0xA5C3.
    clear_rec();
    send_frame(16'hA5C3, t);
    repeat (70) tick();
    check_val("a5c3_sdi", int'(sdi_cap), 16'hA5C3);
    check_val("a5c3_bits", sdi_n, 16);
    check_val("a5c3_le_first", le_first - t, 65);
    check_val("a5c3_le_last", le_last - t, 66);
    check_val("a5c3_le_pulses", le_pulses, 1);
    check_val("a5c3_done", done_cyc - t, 67);
    check_val("a5c3_po", int'(po), 16'hA5C3);

    // Second word held valid while busy is only taken once the first frame completes.
    clear_rec();
    Load_Data = 16'hA5C3; Load_Valid = 1'b1; t = cyc;
    tick();
    Load_Data = 16'h1234;
    w = 0;
    while (!Load_Ready && w < 300) begin tick(); w++; end
    acc = cyc;
    tick();
    Load_Valid = 1'b0;
    check_val("hold_accept", acc - t, 67);
    repeat (70) tick();
    check_val("hold_le_pulses", le_pulses, 2);
    check_val("hold_sdi", int'(sdi_cap), 16'h1234);
    check_val("hold_done", done_cyc - t, 134);
    check_val("hold_po", int'(po), 16'h1234);

    // PWM duty.
    Bright = 4'd4;  repeat (40) tick(); count_on(on_cnt); check_val("pwm_b4", on_cnt, 4);
    Bright = 4'd0;  repeat (40) tick(); count_on(on_cnt); check_val("pwm_b0", on_cnt, 0);
    Bright = 4'd15; repeat (40) tick(); count_on(on_cnt); check_val("pwm_b15", on_cnt, 15);
    repeat (7) tick();
    Bright = 4'd9;  repeat (5) tick();
    Bright = 4'd2;  repeat (40) tick(); count_on(on_cnt); check_val("pwm_mid_change", on_cnt, 2);

    // Reset in the middle of a frame.
    clear_rec();
    send_frame(16'hFFFF, t);
    repeat (19) tick();
    Rst = 1'b1;
    #1;
    check1("rst_clk", LED_Clk, 1'b0);
    check1("rst_sdi", LED_SDI, 1'b0);
    check1("rst_le", LED_LE, 1'b0);
    check1("rst_oe", LED_OE, 1'b1);
    check1("rst_done", Frame_Done, 1'b0);
    check1("rst_err", Readback_Err, 1'b0);
    check1("rst_ready", Load_Ready, 1'b1);
    tick();
    Rst = 1'b0;
    le_snap = le_pulses; done_snap = done_cnt;
    repeat (80) tick();
    check_val("rst_no_le", le_pulses, le_snap);
    check_val("rst_no_done", done_cnt, done_snap);
    check1("rst_ready_after", Load_Ready, 1'b1);
    send_frame(16'h5A3C, t);
    repeat (70) tick();
    check_val("rst_next_sdi", int'(sdi_cap), 16'h5A3C);
    check_val("rst_next_po", int'(po), 16'h5A3C);

`ifdef LED_READBACK_EN
    do_reset(2);
    send_frame(16'h00FF, t); repeat (70) tick();
    check1("rb_first", Readback_Err, 1'b0);
    send_frame(16'hFFFF, t); repeat (70) tick();
    check1("rb_second", Readback_Err, 1'b0);
    force_req = 1'b1;
    send_frame(16'h0F0F, t);
    force_req = 1'b0;
    repeat (70) tick();
    check1("rb_forced", Readback_Err, 1'b1);
`endif

    // Randomized traffic against the reference.
    do_reset(2);
    done_snap = done_cnt;
    for (int i = 0; i < 3000; i++) begin
      Load_Valid = ($urandom_range(0, 3) == 0);
      Load_Data  = N'($urandom);
      force_req  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) Bright = 4'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
      end else begin
        tick();
      end
    end
    Load_Valid = 1'b0;
    repeat (80) tick();
    checks++;
    if (done_cnt - done_snap < 20) begin
      failures++;
      $display("FAIL random_frames actual=%0d expected>=20", done_cnt - done_snap);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
